// File: rtl/tx_tlp_arbiter_pkg.sv
// Shared types for the TX TLP arbiter: FSM states, source ids, link width and
// the round-robin pick helper used by the arbitration cycle.
package tlp_pkg;

  localparam int TLP_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } tx_arb_state_t;

  typedef enum logic {
    SRC_WR = 1'b0,
    SRC_RD = 1'b1
  } tx_src_t;

  // When both are eligible the source that did not win last time goes next.
  function automatic tx_src_t rr_pick(input logic elig_wr, input logic elig_rd,
                                      input tx_src_t last);
    tx_src_t pick;
    if (elig_wr && elig_rd) begin
      pick = (last == SRC_WR) ? SRC_RD : SRC_WR;
    end else if (elig_wr) begin
      pick = SRC_WR;
    end else begin
      pick = SRC_RD;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tx_tlp_arbiter_if.sv
// Bundle of the two TLP sources, the data link layer beat port and the
// credit-return / credit-error sideband seen by the TX arbiter.
interface tx_tlp_arbiter_if;
  import tlp_pkg::*;

  logic [TLP_W-1:0] wr_tlp;
  logic             wr_valid;
  logic             wr_last;
  logic             wr_ready;

  logic [TLP_W-1:0] rd_tlp;
  logic             rd_valid;
  logic             rd_last;
  logic             rd_ready;

  logic [TLP_W-1:0] tlp_out;
  logic             tlp_out_valid;
  logic             tlp_in_ready;

  logic             p_credit_ret;
  logic             np_credit_ret;
  logic             credit_err;

  // Environment side: TLP builders, data link layer and credit returns.
  modport master (
    output wr_tlp, wr_valid, wr_last,
    input  wr_ready,
    output rd_tlp, rd_valid, rd_last,
    input  rd_ready,
    input  tlp_out, tlp_out_valid,
    output tlp_in_ready,
    output p_credit_ret, np_credit_ret,
    input  credit_err
  );

  // Arbiter side.
  modport slave (
    input  wr_tlp, wr_valid, wr_last,
    output wr_ready,
    input  rd_tlp, rd_valid, rd_last,
    output rd_ready,
    output tlp_out, tlp_out_valid,
    input  tlp_in_ready,
    input  p_credit_ret, np_credit_ret,
    output credit_err
  );

endinterface

// File: rtl/tx_tlp_arbiter_credit.sv
// Per-class packet credit counter: one credit consumed per granted packet,
// one restored per return pulse, sticky error on a return while already full.
module tx_credit_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         consume,
  input  logic         ret,
  output logic [W-1:0] avail,
  output logic         err
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  // Next count; a simultaneous consume and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (consume && !ret) begin
      cnt_d = cnt_q - W'(1'b1);
    end else if (ret && !consume) begin
      if (cnt_q == MAX_C) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= MAX_C;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign avail = cnt_q;
  assign err   = err_q;

endmodule

// File: rtl/tx_tlp_arbiter.sv
// Round-robin, packet-atomic arbiter sharing the TX TLP link between the posted
// write path and the non-posted read path, gated by per-class credits.
module tx_tlp_arbiter
  import tlp_pkg::*;
#(
  parameter int P_CREDITS  = 8,
  parameter int NP_CREDITS = 8
) (
  input logic             clk,
  input logic             reset,
  tx_tlp_arbiter_if.slave bus
);

  localparam int PW  = $clog2(P_CREDITS + 1);
  localparam int NPW = $clog2(NP_CREDITS + 1);

  tx_arb_state_t  state_q, state_d;
  tx_src_t        rr_last_q, rr_last_d;

  logic           p_consume_s;
  logic           np_consume_s;
  logic [PW-1:0]  p_cnt_s;
  logic [NPW-1:0] np_cnt_s;
  logic           p_err_s;
  logic           np_err_s;
  logic           elig_wr_s;
  logic           elig_rd_s;
  tx_src_t        pick_s;

  tx_credit_counter #(.MAX(P_CREDITS), .W(PW)) u_p_credit (
    .clk     (clk),
    .reset   (reset),
    .consume (p_consume_s),
    .ret     (bus.p_credit_ret),
    .avail   (p_cnt_s),
    .err     (p_err_s)
  );

  tx_credit_counter #(.MAX(NP_CREDITS), .W(NPW)) u_np_credit (
    .clk     (clk),
    .reset   (reset),
    .consume (np_consume_s),
    .ret     (bus.np_credit_ret),
    .avail   (np_cnt_s),
    .err     (np_err_s)
  );

  // Arbitration decision in IDLE and the beat mux while a grant is held.
  always_comb begin
    state_d           = state_q;
    rr_last_d         = rr_last_q;
    p_consume_s       = 1'b0;
    np_consume_s      = 1'b0;
    bus.tlp_out       = {TLP_W{1'b0}};
    bus.tlp_out_valid = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.rd_ready      = 1'b0;
    elig_wr_s         = bus.wr_valid && (p_cnt_s != {PW{1'b0}});
    elig_rd_s         = bus.rd_valid && (np_cnt_s != {NPW{1'b0}});
    pick_s            = rr_pick(elig_wr_s, elig_rd_s, rr_last_q);

    case (state_q)
      IDLE: begin
        if (elig_wr_s || elig_rd_s) begin
          rr_last_d = pick_s;
          if (pick_s == SRC_WR) begin
            state_d     = GNT_WR;
            p_consume_s = 1'b1;
          end else begin
            state_d      = GNT_RD;
            np_consume_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // The grant is held across source bubbles until the last beat handshakes.
      GNT_WR: begin
        bus.tlp_out       = bus.wr_tlp;
        bus.tlp_out_valid = bus.wr_valid;
        bus.wr_ready      = bus.tlp_in_ready;
        if (bus.wr_valid && bus.tlp_in_ready && bus.wr_last) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_WR;
        end
      end

      GNT_RD: begin
        bus.tlp_out       = bus.rd_tlp;
        bus.tlp_out_valid = bus.rd_valid;
        bus.rd_ready      = bus.tlp_in_ready;
        if (bus.rd_valid && bus.tlp_in_ready && bus.rd_last) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_RD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and round-robin history; write wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_RD;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign bus.credit_err = p_err_s | np_err_s;

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Self-checking bench for tx_tlp_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_tx_tlp_arbiter;
  import tlp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  tx_tlp_arbiter_if bus();

  tx_tlp_arbiter #(.P_CREDITS(8), .NP_CREDITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wv, wl, rv, rl, rdy;
    logic       e_valid, e_wrdy, e_rrdy;
    logic [1:0] e_src;   // 0 none, 1 write, 2 read
    int         e_p, e_np;
  } vec_t;

  vec_t tbl[13];

  localparam logic [63:0] WD = 64'hAAAA_0000_0000_0000;
  localparam logic [63:0] RD = 64'hBBBB_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic wv, input logic wl, input logic rv, input logic rl,
                     input logic rdy, input logic pr, input logic npr);
    @(negedge clk);
    bus.wr_valid = wv; bus.wr_last = wl; bus.wr_tlp = WD;
    bus.rd_valid = rv; bus.rd_last = rl; bus.rd_tlp = RD;
    bus.tlp_in_ready = rdy;
    bus.p_credit_ret = pr; bus.np_credit_ret = npr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_tlp = 64'd0;
    bus.rd_valid = 1'b0; bus.rd_last = 1'b0; bus.rd_tlp = 64'd0;
    bus.tlp_in_ready = 1'b0; bus.p_credit_ret = 1'b0; bus.np_credit_ret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Randomized run: sources present beats with bubbles and hold them until
  // accepted; the model tracks link owner, tie history and credits as integers.
  task automatic random_run(input int n);
    int owner, rr, pc, npc, g;
    bit err;
    bit w_pres, r_pres, w_lst, r_lst;
    int w_rem, r_rem;
    logic [63:0] w_dat, r_dat, e_dat;
    int seq;
    bit e_v, e_wr, e_rr, hs_w, hs_r, pr, npr, cp, cnp;
    owner = 0; rr = 2; pc = 8; npc = 8; err = 1'b0;
    w_pres = 1'b0; r_pres = 1'b0; w_rem = 0; r_rem = 0; seq = 0;
    w_lst = 1'b0; r_lst = 1'b0; w_dat = 64'd0; r_dat = 64'd0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!w_pres && ($urandom % 4 != 0)) begin
        if (w_rem == 0) w_rem = $urandom_range(1, 4);
        w_pres = 1'b1; w_lst = (w_rem == 1); w_dat = {32'h5752_0000, 32'(seq)}; seq++;
      end
      if (!r_pres && ($urandom % 4 != 0)) begin
        if (r_rem == 0) r_rem = $urandom_range(1, 3);
        r_pres = 1'b1; r_lst = (r_rem == 1); r_dat = {32'h5244_0000, 32'(seq)}; seq++;
      end
      pr  = ($urandom % 6 == 0);
      npr = ($urandom % 6 == 0);
      bus.wr_valid = w_pres; bus.wr_last = w_lst; bus.wr_tlp = w_dat;
      bus.rd_valid = r_pres; bus.rd_last = r_lst; bus.rd_tlp = r_dat;
      bus.tlp_in_ready = ($urandom % 4 != 0);
      bus.p_credit_ret = pr; bus.np_credit_ret = npr;
      #1;
      e_v = 1'b0; e_wr = 1'b0; e_rr = 1'b0; e_dat = 64'd0;
      if (owner == 1) begin e_v = w_pres; e_wr = bus.tlp_in_ready; e_dat = w_dat; end
      if (owner == 2) begin e_v = r_pres; e_rr = bus.tlp_in_ready; e_dat = r_dat; end
      chk("rnd_valid", bus.tlp_out_valid, e_v);
      chk("rnd_wr_ready", bus.wr_ready, e_wr);
      chk("rnd_rd_ready", bus.rd_ready, e_rr);
      if (e_v) chk("rnd_data", bus.tlp_out, e_dat);
      else     chk("rnd_data_idle", bus.tlp_out, owner == 0 ? 64'd0 : e_dat);
      chk("rnd_credit_err", bus.credit_err, err);
      chk("rnd_p_cnt", dut.p_cnt_s, pc);
      chk("rnd_np_cnt", dut.np_cnt_s, npc);
      hs_w = w_pres && e_wr;
      hs_r = r_pres && e_rr;
      cp = 1'b0; cnp = 1'b0;
      if (owner == 0) begin
        g = 0;
        if (w_pres && pc > 0 && r_pres && npc > 0) g = (rr == 1) ? 2 : 1;
        else if (w_pres && pc > 0) g = 1;
        else if (r_pres && npc > 0) g = 2;
        if (g != 0) begin owner = g; rr = g; cp = (g == 1); cnp = (g == 2); end
      end else if ((owner == 1 && hs_w && w_lst) || (owner == 2 && hs_r && r_lst)) begin
        owner = 0;
      end
      if (hs_w) begin w_pres = 1'b0; w_rem--; end
      if (hs_r) begin r_pres = 1'b0; r_rem--; end
      if (pr && !cp && pc == 8) err = 1'b1; else pc = pc - int'(cp) + int'(pr);
      if (npr && !cnp && npc == 8) err = 1'b1; else npc = npc - int'(cnp) + int'(npr);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'd0, 8, 8};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 2'd1, 7, 8};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'd1, 7, 8};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0, 2'd1, 7, 8};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0, 2'd1, 7, 8};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'd0, 7, 8};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 2'd0, 7, 8};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 2'd2, 7, 7};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 2'd0, 7, 7};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0, 2'd1, 6, 7};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 2'd0, 6, 7};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 2'd2, 6, 6};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'd0, 6, 6};

    do_reset();
    #1;
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_p_cnt", dut.p_cnt_s, 64'd8);
    chk("rst_np_cnt", dut.np_cnt_s, 64'd8);
    chk("rst_credit_err", bus.credit_err, 1'b0);
    chk("rst_valid", bus.tlp_out_valid, 1'b0);

    // Three-beat write, then alternating single-beat packets.
    for (int i = 0; i < 13; i++) begin
      logic [63:0] wd, rd, ed;
      wd = WD + 64'(i);
      rd = RD + 64'(i);
      @(negedge clk);
      bus.wr_valid = tbl[i].wv; bus.wr_last = tbl[i].wl; bus.wr_tlp = wd;
      bus.rd_valid = tbl[i].rv; bus.rd_last = tbl[i].rl; bus.rd_tlp = rd;
      bus.tlp_in_ready = tbl[i].rdy; bus.p_credit_ret = 1'b0; bus.np_credit_ret = 1'b0;
      #1;
      ed = (tbl[i].e_src == 2'd1) ? wd : (tbl[i].e_src == 2'd2) ? rd : 64'd0;
      chk($sformatf("vec%0d_valid", i), bus.tlp_out_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, tbl[i].e_wrdy);
      chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, tbl[i].e_rrdy);
      chk($sformatf("vec%0d_data", i), bus.tlp_out, ed);
      chk($sformatf("vec%0d_p_cnt", i), dut.p_cnt_s, 64'(tbl[i].e_p));
      chk($sformatf("vec%0d_np_cnt", i), dut.np_cnt_s, 64'(tbl[i].e_np));
    end

    // Exhaust non-posted credits, then release one.
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("np_empty_cnt", dut.np_cnt_s, 64'd0);
    chk("np_empty_rd_ready", bus.rd_ready, 1'b0);
    chk("np_empty_valid", bus.tlp_out_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("np_blocked_state", dut.state_q, IDLE);
    chk("np_blocked_rd_ready", bus.rd_ready, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("np_ret_cnt", dut.np_cnt_s, 64'd1);
    chk("np_ret_state", dut.state_q, IDLE);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("np_9th_state", dut.state_q, GNT_RD);
    chk("np_9th_rd_ready", bus.rd_ready, 1'b1);
    chk("np_9th_data", bus.tlp_out, RD);
    chk("np_9th_cnt", dut.np_cnt_s, 64'd0);

    // Consume and return in the same cycle, then overflow the posted counter.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p_five", dut.p_cnt_s, 64'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p_cons_ret_cnt", dut.p_cnt_s, 64'd5);
    chk("p_cons_ret_state", dut.state_q, GNT_WR);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("p_full_cnt", dut.p_cnt_s, 64'd8);
    chk("p_full_err_before", bus.credit_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p_ovf_err", bus.credit_err, 1'b1);
    chk("p_ovf_cnt", dut.p_cnt_s, 64'd8);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p_err_sticky", bus.credit_err, 1'b1);

    // Reset on beat 2 of a 4-beat write abandons the packet.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_beat1_valid", bus.tlp_out_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_beat2_valid", bus.tlp_out_valid, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.tlp_out_valid, 1'b0);
    chk("mid_rst_state", dut.state_q, IDLE);
    chk("mid_rst_p_cnt", dut.p_cnt_s, 64'd8);
    chk("mid_rst_np_cnt", dut.np_cnt_s, 64'd8);
    chk("mid_rst_err", bus.credit_err, 1'b0);

    do_reset();
    random_run(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
